// File: rtl/apb_i2c_regif.sv
// APB3 register interface for the I2C core: seven-register map, TX/RX FIFO strobes,
// wait-stated RX FIFO reads and sticky W1C interrupt status driving a single IRQ.
module apb_i2c_regif #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned CFG_W  = 14,
   parameter int unsigned TMO_W  = 14,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic [DATA_W-1:0] WRITE_DATA_ON_TX,
   output logic              WR_ENA,
   output logic              RD_ENA,
   input  logic [DATA_W-1:0] READ_DATA_ON_RX,
   input  logic              TX_FULL,
   input  logic              TX_EMPTY,
   input  logic              RX_EMPTY,
   input  logic              ERROR,
   output logic [CFG_W-1:0]  CFG_REG,
   output logic [TMO_W-1:0]  TMO_REG,
   output logic              IRQ
);

   typedef enum logic [1:0] {StIdle, StRdWait, StRdDone} state_t;

   localparam logic [2:0] IdxTx      = 3'd0;
   localparam logic [2:0] IdxRx      = 3'd1;
   localparam logic [2:0] IdxCfg     = 3'd2;
   localparam logic [2:0] IdxTmo     = 3'd3;
   localparam logic [2:0] IdxStat    = 3'd4;
   localparam logic [2:0] IdxIntEn   = 3'd5;
   localparam logic [2:0] IdxIntStat = 3'd6;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                armed_q, armed_d;
   logic                abort_q, abort_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic [CFG_W-1:0]    cfg_q, cfg_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [3:0]          int_en_q, int_en_d;
   logic [3:0]          int_stat_q, int_stat_d;
   logic                tx_empty_q, rx_empty_q, error_q;

   logic [2:0]          idx;
   logic                mapped, acc, err, rx_ok;
   logic [3:0]          clr, set;
   logic [DATA_W-1:0]   rdata;

   assign idx    = PADDR[4:2];
   assign mapped = (PADDR[1:0] == 2'b00) && ((PADDR >> 5) == '0) && (idx != 3'd7);
   // armed blocks an access phase left over from a reset or a completed transfer
   assign acc    = PSEL && PENABLE && armed_q;

   assign err = !mapped
             || ( PWRITE && (idx == IdxRx || idx == IdxStat))
             || (!PWRITE && idx == IdxTx)
             || ( PWRITE && idx == IdxTx && TX_FULL)
             || (!PWRITE && idx == IdxRx && RX_EMPTY);
   assign rx_ok = !PWRITE && idx == IdxRx && !err;

   always_comb begin
      rdata = '0;
      case (idx)
         IdxCfg:     rdata[CFG_W-1:0] = cfg_q;
         IdxTmo:     rdata[TMO_W-1:0] = tmo_q;
         IdxStat:    rdata[3:0]       = {ERROR, RX_EMPTY, TX_FULL, TX_EMPTY};
         IdxIntEn:   rdata[3:0]       = int_en_q;
         IdxIntStat: rdata[3:0]       = int_stat_q;
         default:    rdata            = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      abort_d  = abort_q;
      hold_d   = hold_q;
      cfg_d    = cfg_q;
      tmo_d    = tmo_q;
      int_en_d = int_en_q;
      clr      = '0;
      PREADY   = 1'b0;
      PSLVERR  = 1'b0;
      PRDATA   = '0;
      RD_ENA   = 1'b0;
      WR_ENA   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (acc && rx_ok) begin
               RD_ENA  = 1'b1;
               abort_d = 1'b0;
               cnt_d   = 3'(RD_LAT - 1);
               // Capture on the edge where the counter reaches zero: PREADY stays low RD_LAT cycles
               if (cnt_d == 3'd0) begin
                  hold_d  = READ_DATA_ON_RX;
                  state_d = StRdDone;
               end else begin
                  state_d = StRdWait;
               end
            end else if (acc) begin
               PREADY  = 1'b1;
               PSLVERR = err;
               if (!err && PWRITE) begin
                  case (idx)
                     IdxTx:      WR_ENA   = 1'b1;
                     IdxCfg:     cfg_d    = PWDATA[CFG_W-1:0];
                     IdxTmo:     tmo_d    = PWDATA[TMO_W-1:0];
                     IdxIntEn:   int_en_d = PWDATA[3:0];
                     IdxIntStat: clr      = PWDATA[3:0];
                     default:    clr      = '0;
                  endcase
               end else if (!err) begin
                  PRDATA = rdata;
               end
            end
         end
         StRdWait: begin
            cnt_d = cnt_q - 3'd1;
            if (!PSEL) abort_d = 1'b1;
            if (cnt_q == 3'd1) begin
               hold_d  = READ_DATA_ON_RX;
               state_d = StRdDone;
            end
         end
         StRdDone: begin
            PREADY  = PSEL && PENABLE && !abort_q;
            PRDATA  = abort_q ? '0 : hold_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      armed_d    = !PENABLE || (armed_q && !PREADY);
      set        = {PSLVERR, ERROR && !error_q, !RX_EMPTY && rx_empty_q, TX_EMPTY && !tx_empty_q};
      // Set wins over a same-cycle W1C
      int_stat_d = (int_stat_q & ~clr) | set;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         armed_q    <= 1'b0;
         abort_q    <= 1'b0;
         hold_q     <= '0;
         cfg_q      <= '0;
         tmo_q      <= '0;
         int_en_q   <= '0;
         int_stat_q <= '0;
         tx_empty_q <= 1'b1;
         rx_empty_q <= 1'b1;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         armed_q    <= armed_d;
         abort_q    <= abort_d;
         hold_q     <= hold_d;
         cfg_q      <= cfg_d;
         tmo_q      <= tmo_d;
         int_en_q   <= int_en_d;
         int_stat_q <= int_stat_d;
         tx_empty_q <= TX_EMPTY;
         rx_empty_q <= RX_EMPTY;
         error_q    <= ERROR;
      end
   end

   assign WRITE_DATA_ON_TX = PWDATA;
   assign CFG_REG          = cfg_q;
   assign TMO_REG          = tmo_q;
   assign IRQ              = |(int_stat_q & int_en_q);

endmodule

// File: tb/tb_apb_i2c_regif.sv
// Directed bench for apb_i2c_regif with RD_LAT=3: register map, RX wait states, errors,
// interrupt set/clear and reset in the middle of an RX read.
module tb_apb_i2c_regif;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned CFG_W  = 14;
   localparam int unsigned TMO_W  = 14;
   localparam int unsigned RD_LAT = 3;

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic              PSEL, PENABLE, PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA, PRDATA, WRITE_DATA_ON_TX, READ_DATA_ON_RX;
   logic              PREADY, PSLVERR, WR_ENA, RD_ENA;
   logic              TX_FULL, TX_EMPTY, RX_EMPTY, ERROR, IRQ;
   logic [CFG_W-1:0]  CFG_REG;
   logic [TMO_W-1:0]  TMO_REG;

   int          checks = 0;
   int          errors = 0;
   int          rd_ena_cnt = 0;
   int          wr_ena_cnt = 0;
   logic [31:0] last_tx = '0;

   apb_i2c_regif #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CFG_W(CFG_W), .TMO_W(TMO_W), .RD_LAT(RD_LAT)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .WRITE_DATA_ON_TX(WRITE_DATA_ON_TX), .WR_ENA(WR_ENA), .RD_ENA(RD_ENA),
      .READ_DATA_ON_RX(READ_DATA_ON_RX), .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY),
      .RX_EMPTY(RX_EMPTY), .ERROR(ERROR), .CFG_REG(CFG_REG), .TMO_REG(TMO_REG), .IRQ(IRQ)
   );

   always #5 PCLK = ~PCLK;

   always @(negedge PCLK) begin
      if (RD_ENA) rd_ena_cnt <= rd_ena_cnt + 1;
      if (WR_ENA) begin
         wr_ena_cnt <= wr_ena_cnt + 1;
         last_tx    <= WRITE_DATA_ON_TX;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int waits);
      logic done;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      waits = 0; rdata = '0; err = 1'b0; done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (PREADY) begin
            rdata = PRDATA; err = PSLVERR; done = 1'b1;
            break;
         end
         waits++;
      end
      check("pready_seen", {31'b0, done}, 32'd1);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          wt, cnt0;

   initial begin
      PRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
      TX_FULL = 0; TX_EMPTY = 1; RX_EMPTY = 1; ERROR = 0; READ_DATA_ON_RX = 32'hDEAD_BEEF;
      @(negedge PCLK);
      check("rst_pready", {31'b0, PREADY}, 0);
      check("rst_rdena", {31'b0, RD_ENA}, 0);
      check("rst_irq", {31'b0, IRQ}, 0);
      check("rst_cfg", {18'b0, CFG_REG}, 0);
      @(posedge PCLK); #1 PRESET = 1'b0;

      apb_xfer(0, 8'h08, 0, rd, er, wt); check("rd_config", rd, 0);
      apb_xfer(0, 8'h0C, 0, rd, er, wt); check("rd_timeout", rd, 0);
      apb_xfer(0, 8'h14, 0, rd, er, wt); check("rd_int_en", rd, 0);
      apb_xfer(0, 8'h18, 0, rd, er, wt); check("rd_int_stat", rd, 0);
      apb_xfer(0, 8'h10, 0, rd, er, wt); check("rd_status", rd, 32'h5);
      check("rd_status_waits", wt, 0);
      check("rd_status_err", {31'b0, er}, 0);

      apb_xfer(1, 8'h08, 32'hFFFF_ABCD, rd, er, wt);
      check("wr_cfg_err", {31'b0, er}, 0);
      check("cfg_reg", {18'b0, CFG_REG}, 32'h2BCD);
      apb_xfer(0, 8'h08, 0, rd, er, wt); check("rb_config", rd, 32'h2BCD);
      apb_xfer(1, 8'h0C, 32'h1234_5678, rd, er, wt);
      check("tmo_reg", {18'b0, TMO_REG}, 32'h1678);
      apb_xfer(0, 8'h0C, 0, rd, er, wt); check("rb_timeout", rd, 32'h1678);

      cnt0 = wr_ena_cnt;
      apb_xfer(1, 8'h00, 32'h0000_00A5, rd, er, wt);
      check("tx_err", {31'b0, er}, 0);
      check("tx_wr_ena_cnt", wr_ena_cnt - cnt0, 1);
      check("tx_data", last_tx, 32'hA5);

      // RX read with RD_LAT=3
      #1 RX_EMPTY = 1'b0;
      cnt0 = rd_ena_cnt;
      apb_xfer(0, 8'h04, 0, rd, er, wt);
      check("rx_data", rd, 32'hDEAD_BEEF);
      check("rx_waits", wt, 3);
      check("rx_err", {31'b0, er}, 0);
      check("rx_rd_ena_cnt", rd_ena_cnt - cnt0, 1);
      apb_xfer(0, 8'h18, 0, rd, er, wt); check("int_rx_arrive", rd, 32'h2);
      apb_xfer(1, 8'h18, 32'h2, rd, er, wt);
      apb_xfer(0, 8'h18, 0, rd, er, wt); check("int_w1c_rx", rd, 0);

      #1 TX_EMPTY = 1'b0;
      @(posedge PCLK); @(posedge PCLK); #1 TX_EMPTY = 1'b1;
      @(posedge PCLK); @(posedge PCLK);
      apb_xfer(0, 8'h18, 0, rd, er, wt); check("int_tx_empty", rd, 32'h1);
      apb_xfer(1, 8'h18, 32'h1, rd, er, wt);

      // Error responses
      #1 TX_FULL = 1'b1;
      cnt0 = wr_ena_cnt;
      apb_xfer(1, 8'h04, 32'h11, rd, er, wt);
      check("wr_rx_err", {31'b0, er}, 1);
      check("wr_rx_waits", wt, 0);
      apb_xfer(1, 8'h00, 32'h22, rd, er, wt);
      check("tx_full_err", {31'b0, er}, 1);
      check("tx_full_no_wr", wr_ena_cnt - cnt0, 0);
      apb_xfer(0, 8'h00, 0, rd, er, wt); check("rd_tx_err", {31'b0, er}, 1);
      apb_xfer(0, 8'h09, 0, rd, er, wt); check("unaligned_err", {31'b0, er}, 1);
      apb_xfer(0, 8'h1C, 0, rd, er, wt); check("unmapped_err", {31'b0, er}, 1);
      check("unmapped_rdata", rd, 0);
      apb_xfer(1, 8'h10, 32'hF, rd, er, wt); check("wr_stat_err", {31'b0, er}, 1);
      #1 RX_EMPTY = 1'b1;
      cnt0 = rd_ena_cnt;
      apb_xfer(0, 8'h04, 0, rd, er, wt);
      check("rx_empty_err", {31'b0, er}, 1);
      check("rx_empty_no_rd", rd_ena_cnt - cnt0, 0);
      #1 TX_FULL = 1'b0;
      apb_xfer(0, 8'h18, 0, rd, er, wt); check("int_slverr", rd, 32'h8);
      check("irq_masked", {31'b0, IRQ}, 0);
      apb_xfer(1, 8'h14, 32'h8, rd, er, wt);
      check("irq_on", {31'b0, IRQ}, 1);
      apb_xfer(1, 8'h18, 32'h8, rd, er, wt);
      check("irq_off", {31'b0, IRQ}, 0);

      // ERROR edge, then ERROR rising together with W1C of bit 2
      #1 ERROR = 1'b1;
      @(posedge PCLK); @(posedge PCLK);
      apb_xfer(0, 8'h18, 0, rd, er, wt); check("int_error", rd, 32'h4);
      #1 ERROR = 1'b0;
      apb_xfer(1, 8'h18, 32'h4, rd, er, wt);
      apb_xfer(0, 8'h18, 0, rd, er, wt); check("int_w1c_err", rd, 0);
      @(posedge PCLK); #1;
      PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h18; PWDATA = 32'h4;
      @(posedge PCLK); #1;
      PENABLE = 1; ERROR = 1'b1;
      @(negedge PCLK); check("collide_ready", {31'b0, PREADY}, 1);
      @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
      apb_xfer(0, 8'h18, 0, rd, er, wt); check("set_beats_clear", rd, 32'h4);
      #1 ERROR = 1'b0;

      // Reset during RDWAIT
      apb_xfer(1, 8'h14, 32'hF, rd, er, wt);
      check("irq_pre_reset", {31'b0, IRQ}, 1);
      #1 RX_EMPTY = 1'b0;
      cnt0 = rd_ena_cnt;
      @(posedge PCLK); #1;
      PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 8'h04;
      @(posedge PCLK); #1 PENABLE = 1;
      @(posedge PCLK); #1 PRESET = 1'b1;
      #1;
      check("abort_pready", {31'b0, PREADY}, 0);
      check("abort_rdena", {31'b0, RD_ENA}, 0);
      check("abort_cfg", {18'b0, CFG_REG}, 0);
      check("abort_tmo", {18'b0, TMO_REG}, 0);
      check("abort_irq", {31'b0, IRQ}, 0);
      @(posedge PCLK); @(posedge PCLK); #1;
      PSEL = 0; PENABLE = 0; PRESET = 1'b0;
      @(posedge PCLK); @(posedge PCLK);
      check("abort_one_rdena", rd_ena_cnt - cnt0, 1);
      apb_xfer(0, 8'h10, 0, rd, er, wt);
      check("post_rst_status", rd, 32'h1);
      check("post_rst_waits", wt, 0);
      apb_xfer(0, 8'h14, 0, rd, er, wt); check("post_rst_int_en", rd, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/apb_i2c_regif.md
# apb_i2c_regif

Parameterised APB3 register interface between the APB bus and the I2C core with its TX/RX FIFOs. It decodes a seven-register map and drives FIFO write/read strobes. Reads from the RX FIFO use a wait-stated handshake (PREADY low). Accesses that cannot be honoured return PSLVERR. Individual FIFO/error flags are replaced by sticky, maskable, write-1-to-clear interrupt status feeding a single IRQ line.

## Interface
- DATA_W, 32, APB data width (≥16)
- ADDR_W, 8, decoded PADDR bits; upper bits ignored
- CFG_W, 14, config register width (≤ DATA_W)
- TMO_W, 14, timeout register width (≤ DATA_W)
- RD_LAT, 1, cycles from RD_ENA to valid READ_DATA_ON_RX (1..7)

- PCLK  in  1  clock, rising edge
- PRESET  in  1  reset, asynchronous, active-high
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write
- PADDR  in  ADDR_W  byte address
- PWDATA  in  DATA_W  write data
- PRDATA  out  DATA_W  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error; valid only while PREADY=1
- WRITE_DATA_ON_TX  out  DATA_W  TX FIFO write data
- WR_ENA  out  1  TX FIFO push, one-cycle pulse
- RD_ENA  out  1  RX FIFO pop, one-cycle pulse
- READ_DATA_ON_RX  in  DATA_W  RX FIFO head
- TX_FULL, TX_EMPTY, RX_EMPTY  in  1  FIFO flags
- ERROR  in  1  I2C core error, level
- CFG_REG  out  CFG_W  I2C configuration
- TMO_REG  out  TMO_W  I2C timeout
- IRQ  out  1  OR of (INT_STAT & INT_EN)

## Operation

**Register map**

| Offset | Name | Access | Behaviour |
|---|---|---|---|
| 0x00 | TXDATA | W | Pushes the write to the TX FIFO |
| 0x04 | RXDATA | R | Pops the RX FIFO |
| 0x08 | CONFIG | RW | Drives CFG_REG; zero-extended on read |
| 0x0C | TIMEOUT | RW | Drives TMO_REG; zero-extended on read |
| 0x10 | STATUS | R | [0] TX_EMPTY, [1] TX_FULL, [2] RX_EMPTY, [3] ERROR |
| 0x14 | INT_EN | RW | bits [3:0] |
| 0x18 | INT_STAT | R/W1C | bits [3:0] |

- Unused bits read as 0.

**State machine:** IDLE, RDWAIT, RDDONE.
- IDLE, access phase (PSEL & PENABLE), not a valid RXDATA read:
  - PREADY=1 in the same cycle (zero wait states).
  - Writes commit at that clock edge.
- IDLE, valid RXDATA read:
  - RD_ENA=1 for that cycle and PREADY=0.
  - Load the counter with RD_LAT-1 and go to RDWAIT.
- RDWAIT:
  - PREADY=0.
  - Count down each cycle.
  - At 0, capture READ_DATA_ON_RX into the PRDATA holding register and go to RDDONE.
- RDDONE: PREADY=1, PRDATA = captured value, PSLVERR=0, return to IDLE.

**Errors** (PREADY=1 with zero wait, PSLVERR=1, no side effect, PRDATA=0):
- Write to TXDATA while TX_FULL: no WR_ENA.
- Read of RXDATA while RX_EMPTY: no RD_ENA.
- Unmapped offset, or PADDR[1:0]≠0.
- Write to RXDATA or STATUS, or read of TXDATA.

**Interrupt sources** (INT_STAT bits):
- [0] TX_EMPTY rising edge.
- [1] RX_EMPTY falling edge (data arrived).
- [2] ERROR rising edge.
- [3] any PSLVERR response.

**Interrupt edges and INT_STAT rules:**
- Edges are detected against one-cycle-delayed flag registers.
- Set has priority over a W1C clear of the same bit in the same cycle.
- IRQ is a combinational OR from registers, so it has no dependency on APB inputs.

**Write data:**
- WRITE_DATA_ON_TX = PWDATA unconditionally.
- WR_ENA = PSEL & PENABLE & PWRITE & offset 0x00 & !TX_FULL, in IDLE.

**Reset** (asynchronous, any state, including mid-RDWAIT):
- FSM returns to IDLE.
- Values after reset:
  - PREADY=0, PSLVERR=0, PRDATA=0, RD_ENA=0, WR_ENA=0, IRQ=0.
  - CFG_REG=0, TMO_REG=0, INT_EN=0, INT_STAT=0.
  - Delayed flags load TX_EMPTY=1, RX_EMPTY=1, ERROR=0.
- An aborted read does not re-pulse RD_ENA.

## Timing
- Register read/write: 2 bus cycles (SETUP + 1 ACCESS).
- RXDATA read: 2+RD_LAT bus cycles; RD_ENA is asserted exactly once per successful read.
- CONFIG, TIMEOUT, INT_EN and INT_STAT update at the PCLK edge that ends the ACCESS cycle. New values are visible on CFG_REG/TMO_REG/IRQ in the next cycle.
- INT_STAT bit set: 1 cycle after the flag edge. IRQ follows in the same cycle as the set.
- PSEL deasserted in RDWAIT (protocol violation): the FSM completes to IDLE silently, with no PREADY pulse and the data discarded.
- Back-to-back RXDATA reads: the second RD_ENA occurs no earlier than the cycle after the first read's RDDONE.

## Test plan
- Reset then read every register: CONFIG=0, TIMEOUT=0, INT_EN=0, INT_STAT=0, STATUS=0x5 with TX_EMPTY=1, RX_EMPTY=1; IRQ=0.
- Write CONFIG=0xFFFF_ABCD: CFG_REG=0x2BCD (CFG_W=14), read back 0x0000_2BCD, PSLVERR=0; same check for TIMEOUT.
- RX_EMPTY=0, RD_LAT=3, RX head=0xDEAD_BEEF, read 0x04: one RD_ENA pulse, PREADY low for 3 ACCESS cycles, PRDATA=0xDEADBEEF, 5 cycles total.
- Write 0x04 with TX_FULL=1: PSLVERR=1, WR_ENA=0, INT_STAT[3]=1. Then, with INT_EN=0x8, check IRQ=1; write INT_STAT=0x8 and check IRQ=0 the next cycle.
- Raise ERROR in the same cycle as a W1C of bit 2: INT_STAT[2] stays 1.
- Assert PRESET during RDWAIT: PREADY, RD_ENA and all registers go to 0 immediately; the next read of 0x10 completes normally with zero wait.
